// File: rtl/qrow_action_writer_pkg.sv
// Shared constants, FSM state encoding and the row-packing helper for the
// Q-table row writer.
package qrow_action_writer_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int ACTIONS       = 4;
  localparam int ACTIONS_WIDTH = 2;
  localparam int STATE_WIDTH   = 4;
  localparam int ROW_WIDTH     = DATA_WIDTH * ACTIONS;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    MERGE = 3'd3,
    WRITE = 3'd4
  } state_e;

  // Action 0 sits in the MSB slice, action ACTIONS-1 in the LSB slice.
  function automatic int slice_lsb(input int k);
    return DATA_WIDTH * (ACTIONS - 1 - k);
  endfunction

endpackage

// File: rtl/qrow_action_writer_slice_merge.sv
// Combinational slot replace: overwrite the slice selected by action_i with
// value_i; every other slice passes through untouched.
module qrow_slice_merge
  import qrow_action_writer_pkg::*;
(
  input  logic [ROW_WIDTH-1:0]     row_i,
  input  logic [ACTIONS_WIDTH-1:0] action_i,
  input  logic [DATA_WIDTH-1:0]    value_i,
  output logic [ROW_WIDTH-1:0]     row_o
);

  // An out-of-range action matches no slice, so the row comes back unchanged.
  always_comb begin
    row_o = row_i;
    for (int k = 0; k < ACTIONS; k++) begin
      if (int'(action_i) == k) row_o[slice_lsb(k) +: DATA_WIDTH] = value_i;
    end
  end

endmodule

// File: rtl/qrow_action_writer.sv
// Read-modify-write engine for one Q-table row: read the row, replace one
// action slot with a new Q value, write the row back.
module qrow_action_writer
  import qrow_action_writer_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [STATE_WIDTH-1:0]   i_state,
  input  logic [ACTIONS_WIDTH-1:0] i_action,
  input  logic [DATA_WIDTH-1:0]    i_data,
  output logic                     o_rd_en,
  output logic [STATE_WIDTH-1:0]   o_rd_addr,
  input  logic [ROW_WIDTH-1:0]     i_rd_data,
  output logic                     o_wr_en,
  output logic [STATE_WIDTH-1:0]   o_wr_addr,
  output logic [ROW_WIDTH-1:0]     o_wr_data,
  output logic                     o_done,
  output logic                     o_err
);

  state_e                   state_q, state_d;
  logic [1:0]               cnt_q, cnt_d;
  logic [STATE_WIDTH-1:0]   st_q, st_d;
  logic [ACTIONS_WIDTH-1:0] act_q, act_d;
  logic [DATA_WIDTH-1:0]    dat_q, dat_d;
  logic                     rd_en_q, rd_en_d;
  logic [STATE_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                     wr_en_q, wr_en_d;
  logic [STATE_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [ROW_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     accept, act_ok;
  logic [ROW_WIDTH-1:0]     merged;

  assign accept = i_valid && (state_q == IDLE);
  assign act_ok = int'(act_q) < ACTIONS;

  qrow_slice_merge u_merge (
    .row_i    (i_rd_data),
    .action_i (act_q),
    .value_i  (dat_q),
    .row_o    (merged)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    st_d      = st_q;
    act_d     = act_q;
    dat_d     = dat_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        state_d   = READ;
        st_d      = i_state;
        act_d     = i_action;
        dat_d     = i_data;
        rd_en_d   = 1'b1;
        rd_addr_d = i_state;
      end
      // Read data lands RD_LATENCY cycles after the strobe and is consumed in
      // MERGE, so WAIT spans the RD_LATENCY-1 cycles in between.
      READ: begin
        cnt_d   = 2'(RD_LATENCY - 1);
        state_d = (RD_LATENCY == 1) ? MERGE : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) state_d = MERGE;
      end
      MERGE: begin
        state_d   = WRITE;
        wr_en_d   = act_ok;
        wr_addr_d = st_q;
        wr_data_d = merged;
        done_d    = 1'b1;
        err_d     = !act_ok;
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      st_q      <= '0;
      act_q     <= '0;
      dat_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      st_q      <= st_d;
      act_q     <= act_d;
      dat_q     <= dat_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Strobes are masked by rst_n so a reset asserted during WRITE never commits.
  assign o_ready   = (state_q == IDLE);
  assign o_rd_en   = rd_en_q;
  assign o_rd_addr = rd_addr_q;
  assign o_wr_en   = wr_en_q && rst_n;
  assign o_wr_addr = wr_addr_q;
  assign o_wr_data = wr_data_q;
  assign o_done    = done_q && rst_n;
  assign o_err     = err_q && rst_n;

endmodule

// File: tb/tb_qrow_action_writer.sv
// Self-checking bench: two writers (read latency 1 and 3), each with a RAM
// model, checked against a slot-array reference of the Q-table.
module tb_qrow_action_writer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        v1, v3;
  logic [3:0]  st;
  logic [1:0]  ac;
  logic [31:0] da;

  logic rdy1, rde1, wre1, dn1, er1, rdy3, rde3, wre3, dn3, er3;
  logic [3:0]   rda1, wra1, rda3, wra3;
  logic [127:0] rdd1, wrd1, rdd3, wrd3;

  qrow_action_writer #(.RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_valid(v1), .o_ready(rdy1),
    .i_state(st), .i_action(ac), .i_data(da),
    .o_rd_en(rde1), .o_rd_addr(rda1), .i_rd_data(rdd1),
    .o_wr_en(wre1), .o_wr_addr(wra1), .o_wr_data(wrd1),
    .o_done(dn1), .o_err(er1)
  );

  qrow_action_writer #(.RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .i_valid(v3), .o_ready(rdy3),
    .i_state(st), .i_action(ac), .i_data(da),
    .o_rd_en(rde3), .o_rd_addr(rda3), .i_rd_data(rdd3),
    .o_wr_en(wre3), .o_wr_addr(wra3), .o_wr_data(wrd3),
    .o_done(dn3), .o_err(er3)
  );

  // RAM models with preload port
  logic         pl_en;
  bit           pl_sel;
  logic [3:0]   pl_addr;
  logic [127:0] pl_row;
  logic [127:0] mem1 [16];
  logic [127:0] mem3 [16];
  logic [127:0] p1;
  logic [127:0] q3 [3];

  always @(posedge clk) begin
    if (pl_en && !pl_sel) mem1[pl_addr] <= pl_row;
    else if (wre1)        mem1[wra1]    <= wrd1;
    p1 <= rde1 ? mem1[rda1] : '0;
  end
  assign rdd1 = p1;

  always @(posedge clk) begin
    if (pl_en && pl_sel) mem3[pl_addr] <= pl_row;
    else if (wre3)       mem3[wra3]    <= wrd3;
    q3[0] <= rde3 ? mem3[rda3] : '0;
    q3[1] <= q3[0];
    q3[2] <= q3[1];
  end
  assign rdd3 = q3[2];

  bit cur;
  logic         m_rdy, m_rde, m_wre, m_dn, m_er;
  logic [3:0]   m_rda, m_wra;
  logic [127:0] m_wrd;
  assign m_rdy = cur ? rdy3 : rdy1;
  assign m_rde = cur ? rde3 : rde1;
  assign m_wre = cur ? wre3 : wre1;
  assign m_dn  = cur ? dn3  : dn1;
  assign m_er  = cur ? er3  : er1;
  assign m_rda = cur ? rda3 : rda1;
  assign m_wra = cur ? wra3 : wra1;
  assign m_wrd = cur ? wrd3 : wrd1;

  // Reference: Q values per [instance][state][action]
  logic [31:0] rv [2][16][4];
  int checks = 0;
  int errors = 0;

  function automatic logic [127:0] exp_row(input bit sel, input logic [3:0] s);
    return {rv[sel][s][0], rv[sel][s][1], rv[sel][s][2], rv[sel][s][3]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic set_row(input bit sel, input logic [3:0] s,
                         input logic [31:0] a0, a1, a2, a3);
    rv[sel][s][0] = a0; rv[sel][s][1] = a1; rv[sel][s][2] = a2; rv[sel][s][3] = a3;
    pl_sel = sel; pl_addr = s; pl_row = {a0, a1, a2, a3}; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // One update; hold keeps i_valid high after accept (busy inputs are garbage).
  task automatic run(input bit sel, input logic [3:0] s, input logic [1:0] a,
                     input logic [31:0] d, input bit hold);
    int L, to;
    logic [127:0] exp;
    L = sel ? 3 : 1;
    cur = sel;
    st = s; ac = a; da = d;
    if (sel) v3 = 1'b1; else v1 = 1'b1;
    to = 0;
    while (!m_rdy && to < 50) begin @(posedge clk); #1; to++; end
    chk("ready_wait", 128'(m_rdy), 128'(1'b1));
    @(posedge clk); #1;
    if (!hold) begin v1 = 1'b0; v3 = 1'b0; end
    st = ~s; ac = ~a; da = ~d;
    rv[sel][s][a] = d;
    exp = exp_row(sel, s);
    for (int k = 1; k <= L + 3; k++) begin
      chk("rd_en", 128'(m_rde), 128'(k == 1));
      if (k == 1) chk("rd_addr", 128'(m_rda), 128'(s));
      chk("wr_en", 128'(m_wre), 128'(k == L + 2));
      chk("done", 128'(m_dn), 128'(k == L + 2));
      chk("err", 128'(m_er), 128'(1'b0));
      if (k == L + 2) begin
        chk("wr_addr", 128'(m_wra), 128'(s));
        chk("wr_data", m_wrd, exp);
      end
      chk("ready", 128'(m_rdy), 128'(k == L + 3));
      if (k < L + 3) begin @(posedge clk); #1; end
    end
  endtask

  // Reset asserted in cycle k after accept (dut1: k=2 is MERGE, k=3 is WRITE).
  task automatic reset_mid(input logic [3:0] s, input int k_rst);
    cur = 1'b0;
    st = s; ac = 2'd1; da = $urandom; v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    for (int k = 1; k < k_rst; k++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("rst_wr_en_now", 128'(m_wre), 128'(1'b0));
    chk("rst_done_now", 128'(m_dn), 128'(1'b0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_ready", 128'(m_rdy), 128'(1'b1));
    for (int k = 0; k < 3; k++) begin
      chk("rst_wr_en", 128'(m_wre), 128'(1'b0));
      chk("rst_done", 128'(m_dn), 128'(1'b0));
      chk("rst_rd_en", 128'(m_rde), 128'(1'b0));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; v1 = 1'b0; v3 = 1'b0; pl_en = 1'b0; pl_sel = 1'b0;
    pl_addr = '0; pl_row = '0; st = '0; ac = '0; da = '0; cur = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      cur = (i == 1);
      chk("rst_ready0", 128'(m_rdy), 128'(1'b1));
      chk("rst_rd_en0", 128'(m_rde), 128'(1'b0));
      chk("rst_wr_en0", 128'(m_wre), 128'(1'b0));
      chk("rst_done0", 128'(m_dn), 128'(1'b0));
      chk("rst_err0", 128'(m_er), 128'(1'b0));
      chk("rst_addr0", 128'({m_rda, m_wra}), 128'(0));
      chk("rst_wdata0", m_wrd, 128'(0));
    end
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++)
      set_row(i[4], i[3:0], $urandom, $urandom, $urandom, $urandom);

    // single update, latency 1
    set_row(0, 4'd5, 32'hA, 32'hB, 32'hC, 32'hD);
    run(0, 4'd5, 2'd2, 32'h0000_1234, 0);
    chk("single_const", m_wrd, {32'hA, 32'hB, 32'h1234, 32'hD});

    // slot boundaries over all-zero rows
    set_row(0, 4'd7, 0, 0, 0, 0);
    run(0, 4'd7, 2'd0, 32'hFFFF_FFFF, 0);
    chk("slot0_const", m_wrd, {32'hFFFF_FFFF, 96'h0});
    set_row(0, 4'd8, 0, 0, 0, 0);
    run(0, 4'd8, 2'd3, 32'hFFFF_FFFF, 0);
    chk("slot3_const", m_wrd, {96'h0, 32'hFFFF_FFFF});

    // latency 3 with i_valid held through the first transaction
    run(1, 4'd9, 2'd1, $urandom, 1);
    run(1, 4'd9, 2'd2, $urandom, 0);

    // read-after-write on the same row
    set_row(0, 4'd2, 32'h1, 32'h2, 32'h3, 32'h4);
    run(0, 4'd2, 2'd1, 32'h55, 0);
    run(0, 4'd2, 2'd3, 32'h77, 0);
    chk("raw_const", m_wrd, {32'h1, 32'h55, 32'h3, 32'h77});

    // reset in MERGE, then in WRITE; the rows must stay as they were
    reset_mid(4'd4, 2);
    reset_mid(4'd6, 3);
    run(0, 4'd4, 2'd0, $urandom, 0);
    run(0, 4'd6, 2'd3, $urandom, 0);

    for (int i = 0; i < 24; i++)
      run(i[0], 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), $urandom, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
